// File: rtl/vga_pkg.sv
// Shared 640x480 timing defaults plus width and DAC colour-expansion helpers
// used by the scan controller and its colour expanders.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    // Replicates a BPC-bit channel across 10 DAC bits, MSB first.
    function automatic logic [9:0] expand_channel(input logic [9:0] chan, input int bpc);
        logic [9:0] dac;
        dac = '0;
        for (int i = 0; i < 10; i++) begin
            dac[i] = chan[bpc - 1 - ((9 - i) % bpc)];
        end
        return dac;
    endfunction

endpackage

// File: rtl/vga_colour_expand.sv
// Widens one BPC-bit colour channel to the 10-bit DAC input by repeating
// the channel bits from the MSB down.
module vga_colour_expand
    import vga_pkg::*;
#(
    parameter int BPC = 3
) (
    input  logic [BPC-1:0] channel,
    output logic [9:0]     dac
);

    assign dac = expand_channel(10'(channel), BPC);

endmodule

// File: rtl/vga_scan_controller.sv
// Raster scan generator: walks the pixel/line counters, fetches dots from a
// fixed-latency video memory and emits syncs/blank/colour aligned by PD stages.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 1,
    parameter int BPC         = 3,
    parameter int MEM_LATENCY = 1,
    localparam int DOTS_X     = H_ACTIVE >> SCALE_SHIFT,
    localparam int DOTS_Y     = V_ACTIVE >> SCALE_SHIFT,
    localparam int ADDR_W     = clog2(DOTS_X * DOTS_Y)
) (
    input  logic              vga_clock,
    input  logic              reset,
    input  logic [3*BPC-1:0]  pixel_colour,
    output logic [ADDR_W-1:0] memory_address,
    output logic              mem_rd_en,
    output logic [9:0]        VGA_R,
    output logic [9:0]        VGA_G,
    output logic [9:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK,
    output logic              VGA_SYNC,
    output logic              VGA_CLK,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int PD      = MEM_LATENCY + 2;
    // One spare count of headroom so the sync end bound is representable.
    localparam int H_W     = clog2(H_TOTAL + 1);
    localparam int V_W     = clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEGIN = H_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEGIN = V_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [H_W-1:0]    h_cnt_reg;
    logic [V_W-1:0]    v_cnt_reg;
    logic              visible;
    logic              hs_raw;
    logic              vs_raw;
    logic              first_pos;
    logic [ADDR_W-1:0] x_dot;
    logic [ADDR_W-1:0] y_dot;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              rd_en_reg;
    logic [PD-1:0]     hs_pipe_reg;
    logic [PD-1:0]     vs_pipe_reg;
    logic [PD-1:0]     blank_pipe_reg;
    logic [PD-1:0]     fs_pipe_reg;
    logic [9:0]        dac_rgb [3];
    logic [9:0]        colour_reg [3];

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + V_W'(1);
        end else begin
            h_cnt_reg <= h_cnt_reg + H_W'(1);
        end
    end

    always_comb begin
        visible   = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
        hs_raw    = ((h_cnt_reg >= HS_BEGIN) && (h_cnt_reg < HS_END)) ? HS_POL : ~HS_POL;
        vs_raw    = ((v_cnt_reg >= VS_BEGIN) && (v_cnt_reg < VS_END)) ? VS_POL : ~VS_POL;
        first_pos = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        x_dot     = ADDR_W'(h_cnt_reg >> SCALE_SHIFT);
        y_dot     = ADDR_W'(v_cnt_reg >> SCALE_SHIFT);
        addr_next = '0;
        if (visible) begin
            addr_next = y_dot * ADDR_W'(DOTS_X) + x_dot;
        end
    end

    // Stage PD-1 of each pipe lines up with the colour register output.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            addr_reg       <= '0;
            rd_en_reg      <= 1'b0;
            hs_pipe_reg    <= {PD{~HS_POL}};
            vs_pipe_reg    <= {PD{~VS_POL}};
            blank_pipe_reg <= '0;
            fs_pipe_reg    <= '0;
        end else begin
            addr_reg       <= addr_next;
            rd_en_reg      <= visible;
            hs_pipe_reg    <= {hs_pipe_reg[PD-2:0], hs_raw};
            vs_pipe_reg    <= {vs_pipe_reg[PD-2:0], vs_raw};
            blank_pipe_reg <= {blank_pipe_reg[PD-2:0], visible};
            fs_pipe_reg    <= {fs_pipe_reg[PD-2:0], first_pos};
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            vga_colour_expand #(
                .BPC(BPC)
            ) u_expand (
                .channel(pixel_colour[(2-gi)*BPC +: BPC]),
                .dac    (dac_rgb[gi])
            );
        end
    endgenerate

    // Blank stage PD-2 belongs to the dot whose memory data is arriving now.
    always_ff @(posedge vga_clock) begin
        for (int c = 0; c < 3; c++) begin
            if (reset || !blank_pipe_reg[PD-2]) begin
                colour_reg[c] <= '0;
            end else begin
                colour_reg[c] <= dac_rgb[c];
            end
        end
    end

    assign memory_address = addr_reg;
    assign mem_rd_en      = rd_en_reg;
    assign VGA_R          = colour_reg[0];
    assign VGA_G          = colour_reg[1];
    assign VGA_B          = colour_reg[2];
    assign VGA_HS         = hs_pipe_reg[PD-1];
    assign VGA_VS         = vs_pipe_reg[PD-1];
    assign VGA_BLANK      = blank_pipe_reg[PD-1];
    assign frame_start    = fs_pipe_reg[PD-1];
    assign VGA_SYNC       = 1'b1;
    assign VGA_CLK        = vga_clock;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Self-checking bench: three scan controllers (default 640x480, scaled 640x480,
// small custom raster) checked cycle by cycle against an arithmetic raster model.
module tb_vga_scan_controller;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, ss, ml, bpc;
        bit hpol, vpol;
    } geo_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd, hs, vs, blank, fs;
        logic [9:0]  r, gr, bl;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   key   = 0;
    geo_t geo [3];
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

    // Instance 0: defaults.
    logic [8:0]  pix0;
    logic [16:0] addr0;
    logic        rd0, hs0, vs0, blk0, sync0, clko0, fs0;
    logic [9:0]  r0, g0, b0;
    // Instance 1: 640x480, SCALE_SHIFT=2, MEM_LATENCY=3, BPC=1.
    logic [2:0]  pix1;
    logic [14:0] addr1;
    logic        rd1, hs1, vs1, blk1, sync1, clko1, fs1;
    logic [9:0]  r1, g1, b1;
    // Instance 2: small 28x17 raster, positive HS, BPC=5, MEM_LATENCY=2.
    logic [14:0] pix2;
    logic [5:0]  addr2;
    logic        rd2, hs2, vs2, blk2, sync2, clko2, fs2;
    logic [9:0]  r2, g2, b2;

    vga_scan_controller dut0 (
        .vga_clock(clk), .reset(rst0), .pixel_colour(pix0), .memory_address(addr0),
        .mem_rd_en(rd0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0),
        .VGA_BLANK(blk0), .VGA_SYNC(sync0), .VGA_CLK(clko0), .frame_start(fs0)
    );

    vga_scan_controller #(
        .SCALE_SHIFT(2), .MEM_LATENCY(3), .BPC(1)
    ) dut1 (
        .vga_clock(clk), .reset(rst1), .pixel_colour(pix1), .memory_address(addr1),
        .mem_rd_en(rd1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK(blk1), .VGA_SYNC(sync1), .VGA_CLK(clko1), .frame_start(fs1)
    );

    vga_scan_controller #(
        .H_ACTIVE(20), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_ACTIVE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .SCALE_SHIFT(1), .BPC(5), .MEM_LATENCY(2)
    ) dut2 (
        .vga_clock(clk), .reset(rst2), .pixel_colour(pix2), .memory_address(addr2),
        .mem_rd_en(rd2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2),
        .VGA_BLANK(blk2), .VGA_SYNC(sync2), .VGA_CLK(clko2), .frame_start(fs2)
    );

    // Video memory contents: a keyed pattern of the dot address.
    function automatic int mem_word(int a, int bpc);
        return (a ^ key) & ((1 << (3 * bpc)) - 1);
    endfunction

    // Latency-matched memories, one register per clock of read latency.
    logic [8:0]  m0_q;
    logic [2:0]  m1_q [3];
    logic [14:0] m2_q [2];
    always @(posedge clk) begin
        m0_q    <= 9'(mem_word(int'(addr0), 3));
        m1_q[0] <= 3'(mem_word(int'(addr1), 1));
        m1_q[1] <= m1_q[0];
        m1_q[2] <= m1_q[1];
        m2_q[0] <= 15'(mem_word(int'(addr2), 5));
        m2_q[1] <= m2_q[0];
    end
    assign pix0 = m0_q;
    assign pix1 = m1_q[2];
    assign pix2 = m2_q[1];

    function automatic logic [9:0] expand10(int c, int bpc);
        logic [9:0] e;
        for (int k = 0; k < 10; k++) e[9-k] = c[bpc - 1 - (k % bpc)];
        return e;
    endfunction

    // Expected observation n cycles after the reset edge: the address stage shows
    // raster position n-1, the video outputs show position n-PD.
    function automatic obs_t model(geo_t g, int n);
        obs_t o;
        int   ht, vt, pd, p, h, v, d, m, dot;
        ht = g.ha + g.hf + g.hsw + g.hb;
        vt = g.va + g.vf + g.vsw + g.vb;
        pd = g.ml + 2;
        o = '0;
        o.hs = ~g.hpol;
        o.vs = ~g.vpol;
        if (n >= 1) begin
            p = n - 1; h = p % ht; v = (p / ht) % vt;
            if (h < g.ha && v < g.va) begin
                o.addr = 32'((v >> g.ss) * (g.ha >> g.ss) + (h >> g.ss));
                o.rd   = 1'b1;
            end
        end
        if (n >= pd) begin
            p = n - pd; h = p % ht; v = (p / ht) % vt;
            o.hs    = (h >= g.ha + g.hf && h < g.ha + g.hf + g.hsw) ? g.hpol : ~g.hpol;
            o.vs    = (v >= g.va + g.vf && v < g.va + g.vf + g.vsw) ? g.vpol : ~g.vpol;
            o.fs    = (h == 0 && v == 0);
            o.blank = (h < g.ha && v < g.va);
            if (o.blank) begin
                dot  = (v >> g.ss) * (g.ha >> g.ss) + (h >> g.ss);
                d    = mem_word(dot, g.bpc);
                m    = (1 << g.bpc) - 1;
                o.r  = expand10((d >> (2 * g.bpc)) & m, g.bpc);
                o.gr = expand10((d >> g.bpc) & m, g.bpc);
                o.bl = expand10(d & m, g.bpc);
            end
        end
        return o;
    endfunction

    function automatic obs_t sample(int which);
        obs_t o;
        o = '0;
        case (which)
            0: begin o.addr = 32'(addr0); o.rd = rd0; o.hs = hs0; o.vs = vs0; o.blank = blk0;
                     o.fs = fs0; o.r = r0; o.gr = g0; o.bl = b0; end
            1: begin o.addr = 32'(addr1); o.rd = rd1; o.hs = hs1; o.vs = vs1; o.blank = blk1;
                     o.fs = fs1; o.r = r1; o.gr = g1; o.bl = b1; end
            default: begin o.addr = 32'(addr2); o.rd = rd2; o.hs = hs2; o.vs = vs2; o.blank = blk2;
                     o.fs = fs2; o.r = r2; o.gr = g2; o.bl = b2; end
        endcase
        return o;
    endfunction

    task automatic set_rst(int which, logic v);
        case (which)
            0: rst0 = v;
            1: rst1 = v;
            default: rst2 = v;
        endcase
    endtask

    // Holds reset across one edge; returns mid-cycle at raster position (0,0).
    task automatic release_reset(int which);
        @(negedge clk);
        set_rst(which, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rst(which, 1'b0);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            got = sample(w);
            exp = model(geo[w], 0);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_state dut%0d got=%h want=%h", w, got, exp);
            end
        end
        total++;
        if ({sync0, sync1, sync2} !== 3'b111 || clko0 !== clk) begin
            bad++;
            $display("FAIL sync_clk_low got=%b%b%b/%b want=111/%b", sync0, sync1, sync2, clko0, clk);
        end
        @(posedge clk);
        #1;
        total++;
        if (clko2 !== clk) begin
            bad++;
            $display("FAIL vga_clk_high got=%b want=%b", clko2, clk);
        end
        $display("test_reset done");
    endtask

    task automatic test_hsync_timing();
        obs_t got, exp;
        int   lf = 0, fall1 = -1, rise1 = -1, fall2 = -1;
        logic prev_hs;
        release_reset(0);
        prev_hs = hs0;
        for (int n = 0; n <= 2415 && lf < 8; n++) begin
            if (n > 0) @(negedge clk);
            got = sample(0);
            exp = model(geo[0], n);
            total++;
            if (got !== exp) begin
                bad++; lf++;
                $display("FAIL stream_default n=%0d got=%h want=%h", n, got, exp);
            end
            if (prev_hs === 1'b1 && hs0 === 1'b0) begin
                if (fall1 < 0) fall1 = n; else if (fall2 < 0) fall2 = n;
            end
            if (prev_hs === 1'b0 && hs0 === 1'b1 && rise1 < 0) rise1 = n;
            prev_hs = hs0;
            if (n == 2406) begin
                total++;
                if (addr0 !== 17'd322) begin
                    bad++;
                    $display("FAIL addr_h5_v3 got=%0d want=322", addr0);
                end
            end
            if (n == 2408) begin
                total++;
                if (r0 !== 10'b1011011011) begin
                    bad++;
                    $display("FAIL red_101_expand got=%b want=1011011011", r0);
                end
            end
            if (n == 703) begin
                total++;
                if (r0 !== 10'd0) begin
                    bad++;
                    $display("FAIL red_in_blanking got=%b want=0", r0);
                end
            end
        end
        total++;
        if (fall1 != 659 || rise1 - fall1 != 96 || fall2 - fall1 != 800) begin
            bad++;
            $display("FAIL hsync_timing got start=%0d width=%0d period=%0d want 659/96/800",
                     fall1, rise1 - fall1, fall2 - fall1);
        end
        $display("test_hsync_timing done");
    endtask

    task automatic test_scaled_pipeline();
        obs_t got, exp;
        int   lf = 0, first_blank = -1;
        release_reset(1);
        for (int n = 0; n <= 1700 && lf < 8; n++) begin
            if (n > 0) @(negedge clk);
            got = sample(1);
            exp = model(geo[1], n);
            total++;
            if (got !== exp) begin
                bad++; lf++;
                $display("FAIL stream_scaled n=%0d got=%h want=%h", n, got, exp);
            end
            if (blk1 === 1'b1 && first_blank < 0) first_blank = n;
        end
        total++;
        if (first_blank != 5) begin
            bad++;
            $display("FAIL scaled_blank_latency got=%0d want=5", first_blank);
        end
        $display("test_scaled_pipeline done");
    endtask

    task automatic test_small_frame();
        obs_t got, exp;
        int   lf = 0, max_addr = -1;
        int   pulses [$];
        release_reset(2);
        for (int n = 0; n <= 1438 && lf < 8; n++) begin
            if (n > 0) @(negedge clk);
            got = sample(2);
            exp = model(geo[2], n);
            total++;
            if (got !== exp) begin
                bad++; lf++;
                $display("FAIL stream_small n=%0d got=%h want=%h", n, got, exp);
            end
            if (fs2 === 1'b1) pulses.push_back(n);
            if (rd2 === 1'b1 && int'(addr2) > max_addr) max_addr = int'(addr2);
        end
        total++;
        if (pulses.size() != 4 || pulses[0] != 4 || pulses[1] - pulses[0] != 476) begin
            bad++;
            $display("FAIL frame_period got count=%0d first=%0d period=%0d want 4/4/476",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1,
                     (pulses.size() > 1) ? pulses[1] - pulses[0] : -1);
        end
        total++;
        if (max_addr != 59) begin
            bad++;
            $display("FAIL last_dot_addr got=%0d want=59", max_addr);
        end
        $display("test_small_frame done");
    endtask

    task automatic test_reset_midframe();
        obs_t got, exp;
        int   lf = 0, stop_n, first_fs = -1;
        release_reset(2);
        stop_n = 8 * 28 + 1 + $urandom_range(0, 27);
        for (int n = 1; n <= stop_n; n++) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int n = 0; n <= 490 && lf < 8; n++) begin
            if (n > 0) @(negedge clk);
            got = sample(2);
            exp = model(geo[2], n);
            total++;
            if (got !== exp) begin
                bad++; lf++;
                $display("FAIL midframe_reset n=%0d got=%h want=%h", n, got, exp);
            end
            if (fs2 === 1'b1 && first_fs < 0) first_fs = n;
        end
        total++;
        if (first_fs != 4) begin
            bad++;
            $display("FAIL fs_after_reset got=%0d want=4", first_fs);
        end
        $display("test_reset_midframe done (reset at n=%0d)", stop_n);
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        int   lf = 0, len;
        for (int it = 0; it < 4; it++) begin
            release_reset(0);
            len = $urandom_range(3, 1200);
            for (int n = 0; n <= len && lf < 8; n++) begin
                if (n > 0) @(negedge clk);
                got = sample(0);
                exp = model(geo[0], n);
                total++;
                if (got !== exp) begin
                    bad++; lf++;
                    $display("FAIL back_to_back it=%0d n=%0d got=%h want=%h", it, n, got, exp);
                end
            end
            $display("test_back_to_back run %0d len=%0d", it, len);
        end
    endtask

    initial begin
        // Bits [8:6] cleared so dot 322 carries red 3'b101 on the default raster.
        key    = int'($urandom & 32'hFFFF_FE3F);
        geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1, 3, 1'b0, 1'b0};
        geo[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 3, 1, 1'b0, 1'b0};
        geo[2] = '{20, 2, 4, 2, 12, 1, 2, 2, 1, 2, 5, 1'b1, 1'b0};
        test_reset();
        test_hsync_timing();
        test_scaled_pipeline();
        test_small_frame();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
